// File: rtl/neurocore_uart_pkg.sv
// Shared constants and helpers for the neural chip's UART command/result paths.
package neurocore_uart_pkg;

  // Transmit engine states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int BITS_PER_BYTE        = 8;
  localparam int BYTES_PER_WORD       = 2;
  localparam int DEFAULT_CLKS_PER_BIT = 87;  // 10 MHz / 115200 baud

  // Width of a level counter that must represent 0..depth inclusive
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous word FIFO; shared by the result transmit path and the
// operand buffering on the receive side. Pushes while full and pops while
// empty are ignored, so the level can never wrap.
module result_fifo
  import neurocore_uart_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 4,
  localparam int LVL_W  = level_width(DEPTH),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and level bookkeeping; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_result_tx.sv
// Result transmit path: buffers 16-bit result words and sends each one as two
// back-to-back 8N1 frames on TXD, high byte first, bits LSB first.
module uart_result_tx
  import neurocore_uart_pkg::*;
#(
  parameter int  CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int  WORD_W       = 16,
  parameter int  FIFO_DEPTH   = 4,
  localparam int LVL_W        = level_width(FIFO_DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] WORD_DATA,
  input  logic              WORD_VALID,
  output logic              WORD_READY,
  output logic              TXD,
  output logic              TX_BUSY,
  output logic [LVL_W-1:0]  FIFO_LEVEL
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int               IDX_W    = $clog2(BITS_PER_BYTE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_BYTE - 1);

  logic [1:0]               state;
  logic [CNT_W-1:0]         baud_cnt;
  logic [IDX_W-1:0]         bit_idx;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     byte_sel;
  logic                     txd_q;
  logic                     baud_end;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [WORD_W-1:0]        fifo_dout;
  logic [WORD_W-1:0]        shift_word;
  logic [BITS_PER_BYTE-1:0] cur_byte;

  result_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (WORD_VALID),
    .pop   (fifo_pop),
    .din   (WORD_DATA),
    .dout  (fifo_dout),
    .level (FIFO_LEVEL),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_cnt == CNT_LAST);
  // A new word is taken either from idle or at the very end of the second
  // stop bit, which is what makes streaming gap-free.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && baud_end && byte_sel));
  assign cur_byte = byte_sel ? shift_word[BITS_PER_BYTE-1:0]
                             : shift_word[WORD_W-1 -: BITS_PER_BYTE];
  assign nxt_idx  = bit_idx + IDX_W'(1);

  assign WORD_READY = !fifo_full;
  assign TXD        = txd_q;
  assign TX_BUSY    = (state != ST_IDLE) || !fifo_empty;

  // Frame engine: TXD is registered and changes on the same edge as the state
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      if ((state == ST_IDLE) || baud_end) baud_cnt <= '0;
      else                                baud_cnt <= baud_cnt + CNT_W'(1);

      if (fifo_pop) begin
        state    <= ST_START;
        byte_sel <= 1'b0;
        txd_q    <= 1'b0;
      end else begin
        case (state)
          ST_START: if (baud_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            txd_q   <= cur_byte[0];
          end
          ST_DATA: if (baud_end) begin
            if (bit_idx == IDX_LAST) begin
              state <= ST_STOP;
              txd_q <= 1'b1;
            end else begin
              bit_idx <= nxt_idx;
              txd_q   <= cur_byte[nxt_idx];
            end
          end
          ST_STOP: if (baud_end) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              state    <= ST_START;
              txd_q    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              txd_q <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            txd_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Word being serialised; pure data, captured on every pop
  always_ff @(posedge CLK) begin
    if (fifo_pop) shift_word <= fifo_dout;
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: a queue of expected per-cycle TXD cells is built
// from every accepted word and compared cycle by cycle, together with the
// expected FIFO level, ready and busy flags.
`timescale 1ns/1ps
module tb_uart_result_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic [15:0]      WORD_DATA = '0;
  logic             WORD_VALID = 1'b0;
  logic             WORD_READY;
  logic             TXD;
  logic             TX_BUSY;
  logic [LVL_W-1:0] FIFO_LEVEL;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic exp_cells[$];  // TXD value for each future cycle
  bit   exp_start[$];  // marks the first cell of each word (that cycle pops the FIFO)
  int   m_lvl = 0;     // words accepted but not yet started
  bit   m_acc;
  bit   m_inword;
  logic m_txd;

  uart_result_tx #(
    .CLKS_PER_BIT (CPB),
    .WORD_W       (16),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .WORD_DATA  (WORD_DATA),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .TXD        (TXD),
    .TX_BUSY    (TX_BUSY),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_cells.delete();
    exp_start.delete();
    m_lvl    = 0;
    m_inword = 1'b0;
    m_txd    = 1'b1;
  endtask

  // Two frames per word: start, 8 data bits LSB first, stop; high byte first
  task automatic add_word(input logic [15:0] w);
    logic [7:0] b;
    logic       v;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? w[15:8] : w[7:0];
      for (int c = 0; c < 10; c++) begin
        if (c == 0)      v = 1'b0;
        else if (c == 9) v = 1'b1;
        else             v = b[c-1];
        for (int j = 0; j < CPB; j++) begin
          exp_cells.push_back(v);
          exp_start.push_back(k == 0 && c == 0 && j == 0);
        end
      end
    end
  endtask

  task automatic model_edge();
    m_acc = WORD_VALID && (m_lvl < DEPTH);
    if (exp_cells.size() > 0) begin
      m_txd = exp_cells.pop_front();
      if (exp_start.pop_front()) m_lvl--;
      m_inword = 1'b1;
    end else begin
      m_txd    = 1'b1;
      m_inword = 1'b0;
    end
    if (m_acc) begin
      m_lvl++;
      add_word(WORD_DATA);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("txd",   32'(TXD),        32'(m_txd));
    check("level", 32'(FIFO_LEVEL), 32'(m_lvl));
    check("ready", 32'(WORD_READY), 32'(m_lvl < DEPTH));
    check("busy",  32'(TX_BUSY),    32'(m_inword || (m_lvl > 0)));
  endtask

  task automatic push_word(input logic [15:0] w, input int budget);
    int n;
    bit done;
    WORD_VALID = 1'b1;
    WORD_DATA  = w;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      done = m_acc;
      n++;
    end
    WORD_VALID = 1'b0;
    if (!done) check("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_cells.size() > 0 || m_lvl > 0) && n < budget) begin
      step();
      n++;
    end
    check("idle_reached", 32'(exp_cells.size() + m_lvl), 32'd0);
    step();
  endtask

  initial begin
    int n;
    int pre;
    model_reset();

    // Reset state, during and after reset
    repeat (3) @(posedge CLK);
    #1;
    check("rst_txd",   32'(TXD),        32'd1);
    check("rst_ready", 32'(WORD_READY), 32'd1);
    check("rst_busy",  32'(TX_BUSY),    32'd0);
    check("rst_level", 32'(FIFO_LEVEL), 32'd0);
    RESET = 1'b1;
    step();
    check("rel_txd",   32'(TXD),        32'd1);
    check("rel_level", 32'(FIFO_LEVEL), 32'd0);

    // Single word: first cell at the edge after the push, 80 cycles to idle
    push_word(16'hA55A, 4);
    step();
    check("a55a_fall", 32'(TXD), 32'd0);
    n = 0;
    while (TX_BUSY && n < 200) begin
      step();
      n++;
    end
    check("a55a_len", 32'(n), 32'd80);
    wait_idle(50);

    // Four words on consecutive cycles
    push_word(16'h0001, 4);
    push_word(16'h00FF, 4);
    push_word(16'h1234, 4);
    push_word(16'hFFFF, 4);
    check("burst_lvl",   32'(FIFO_LEVEL), 32'd3);
    check("burst_ready", 32'(WORD_READY), 32'd1);
    wait_idle(600);

    // Overflow: six held pushes while the engine is busy
    push_word(16'h1111, 4);
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      push_word(16'($urandom), 400);
      if (i == 3) begin
        check("full_lvl",   32'(FIFO_LEVEL), 32'd4);
        check("full_ready", 32'(WORD_READY), 32'd0);
      end
    end
    wait_idle(1000);

    // Push on the same edge that the end of word N pops word N+1
    push_word(16'h8001, 4);
    push_word(16'h7E3C, 4);
    n = 0;
    while (!(exp_start.size() > 0 && exp_start[0]) && n < 200) begin
      step();
      n++;
    end
    check("simul_found", 32'(exp_start.size() > 0 && exp_start[0]), 32'd1);
    pre = m_lvl;
    WORD_VALID = 1'b1;
    WORD_DATA  = 16'hC0DE;
    step();
    WORD_VALID = 1'b0;
    check("simul_acc", 32'(m_acc), 32'd1);
    check("simul_lvl", 32'(FIFO_LEVEL), 32'(pre));
    wait_idle(600);

    // Randomised traffic with held-valid producer
    for (int c = 0; c < 800; c++) begin
      if (!WORD_VALID && ($urandom % 3 == 0)) begin
        WORD_VALID = 1'b1;
        WORD_DATA  = 16'($urandom);
      end
      step();
      if (m_acc) WORD_VALID = 1'b0;
    end
    WORD_VALID = 1'b0;
    wait_idle(2000);

    // Reset in the middle of data bit 3 of the first byte
    push_word(16'hC3A5, 4);
    repeat (18) step();
    #2;
    RESET = 1'b0;
    #1;
    check("mid_txd",   32'(TXD),        32'd1);
    check("mid_level", 32'(FIFO_LEVEL), 32'd0);
    check("mid_busy",  32'(TX_BUSY),    32'd0);
    check("mid_ready", 32'(WORD_READY), 32'd1);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    repeat (100) step();
    check("post_txd", 32'(TXD), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
- UART transmit path of the neural chip; the sending counterpart of the chip's RXD command/operand receiver.
- Accepts 16-bit result words from the matrix-multiply datapath over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word as two 8N1 UART frames on TXD back to the host.
- Sits between the multiplier result mux and the TXD pin.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal range >= 2
- WORD_W, 16, result word width; fixed at 16 (two bytes per word)
- FIFO_DEPTH, 4, word FIFO entries; power of two, >= 2

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous active-low reset
- WORD_DATA  in  16  result word to send
- WORD_VALID  in  1  WORD_DATA valid this cycle
- WORD_READY  out  1  FIFO can accept a word; equals !full, combinational from the FIFO level
- TXD  out  1  UART serial output, idle high, registered
- TX_BUSY  out  1  high while FIFO is non-empty or a frame is in progress
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (async, RESET=0): TXD=1, FIFO_LEVEL=0, TX_BUSY=0, WORD_READY=1, state=IDLE, all counters 0. A frame in flight is aborted: TXD goes high immediately and FIFO contents are discarded.
- Push: on a rising edge with WORD_VALID && WORD_READY, the word is written and the level increments.
  - WORD_VALID while full is ignored; the word is not stored.
  - The producer must hold the word until ready.
- Pop: in IDLE with level > 0, the head word is latched into the shift register on the edge, and state goes to START with TXD<=0 on that same edge.
  - A word pushed into an empty FIFO at edge t drives TXD low at edge t+1.
- Simultaneous push and pop in one cycle (not full): level is unchanged and both operations take effect.
- Byte order: high byte (WORD_DATA[15:8]) first, then low byte. Bits within a byte go LSB first.
- States (engine):
  - IDLE: TXD=1.
  - START: TXD=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, each held CLKS_PER_BIT cycles, bit index 0..7, then STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles. Then:
    - byte_sel==0: byte_sel<=1, go to START with no idle gap.
    - byte_sel==1 and FIFO non-empty: pop and go to START (back-to-back words).
    - Otherwise: IDLE.
- Timing:
  - One word takes exactly 20*CLKS_PER_BIT cycles from TXD falling to the end of the second stop bit.
  - Continuous streaming has no idle cycles between frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The bit or state advances on the cycle the counter equals CLKS_PER_BIT-1. The counter is cleared on every state entry.
- TX_BUSY = (state != IDLE) || (level != 0), registered or derived from registered state only.
- FIFO pointers wrap modulo FIFO_DEPTH. Level saturates by construction: no push when full, no pop when empty.

Decomposition:
- Package neurocore_uart_pkg:
  - tx state encoding (IDLE, START, DATA, STOP)
  - BITS_PER_BYTE=8
  - BYTES_PER_WORD=2
  - default CLKS_PER_BIT
  - function for the level width
- One sub-module: result_fifo, a synchronous FIFO with async active-low reset.
  - Ports: push/pop/din/dout/level/full/empty.
  - It is shared with the receive path's operand buffering.
- The top-level engine lives in uart_result_tx.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset check: RESET low then high -> TXD=1, WORD_READY=1, TX_BUSY=0, FIFO_LEVEL=0.
- Single word 0xA55A pushed at edge t:
  - TXD falls at t+1.
  - Expected 4-cycle bit cells: 0,1,0,1,0,0,1,0,1,1 (0xA5, LSB first), then 0,0,1,0,1,1,0,1,0,1 (0x5A).
  - Back in IDLE after exactly 80 cycles; TX_BUSY drops at the same time.
- Push 0x0001,0x00FF,0x1234,0xFFFF on consecutive cycles:
  - Level reaches 3 (one popped immediately) and WORD_READY stays high.
  - 8 frames with no idle cells between them; decoded bytes 00 01 00 FF 12 34 FF FF.
- Overflow: push 6 words while the engine is busy:
  - WORD_READY low once level=4.
  - Held VALID words are not lost.
  - The decoded stream matches the push order exactly.
- Simultaneous push/pop: push on the same edge the STOP of word N pops word N+1 -> level unchanged and the next START follows with no gap.
- Reset mid-frame: assert RESET during the DATA bit 3 of the first byte -> TXD=1 immediately, level=0. After release with no push, TXD stays 1 for 100 cycles.
